sort_step_scheduler: RTL and testbench
======================================

SORT_STEP_SCHEDULER -- requirements
Module: sort_step_scheduler

Interface
REQ-001 The block SHALL have parameter FAST_DIV, default 25_000_000, meaning the clk_100mhz cycles per internal fast strobe (4 Hz).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of step_count.
REQ-003 clk_100mhz  input  1  system clock; all logic on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 tick_1hz  input  1  single-cycle 1 Hz pulse from the clock divider.
REQ-006 btn_start  input  1  single-cycle debounced start pulse.
REQ-007 btn_pause  input  1  single-cycle debounced pause/resume toggle pulse.
REQ-008 btn_step  input  1  single-cycle debounced single-step pulse.
REQ-009 speed_sel  input  2  pace: 00 every tick, 01 every 2nd tick, 10 internal fast strobe, 11 back-to-back.
REQ-010 step_req  output  1  request to the sort engine to perform one compare/swap.
REQ-011 step_ack  input  1  single-cycle engine acceptance of step_req.
REQ-012 sort_done  input  1  level; engine reports the array is fully sorted.
REQ-013 sort_start  output  1  single-cycle pulse telling the engine to reload the array and restart.
REQ-014 state  output  2  current FSM state code.
REQ-015 step_count  output  CNT_W  acknowledged steps since last start; saturates at all-ones.

Function
REQ-016 The FSM SHALL have states IDLE=00, RUN=01, PAUSE=10, DONE=11.
REQ-017 IDLE->RUN on btn_start; sort_start SHALL pulse high in the cycle after btn_start, and step_count SHALL clear to 0 in that same cycle.
REQ-018 RUN->PAUSE on btn_pause; PAUSE->RUN on btn_pause.
REQ-019 RUN or PAUSE->DONE when sort_done=1 and no request is outstanding.
REQ-020 DONE->RUN on btn_start, with sort_start pulse and step_count clear as in REQ-017.
REQ-021 btn_start SHALL be ignored in RUN and PAUSE; btn_pause and btn_step SHALL be ignored in IDLE and DONE.
REQ-022 Pacing strobe: 00 = tick_1hz; 01 = every 2nd tick_1hz; 10 = pulse every FAST_DIV cycles; 11 = constant 1.
REQ-023 The pace counters SHALL clear whenever speed_sel changes or the FSM enters RUN.
REQ-024 In RUN, a pacing strobe at cycle N with no outstanding request and sort_done=0 SHALL raise step_req at N+1.
REQ-025 step_req SHALL hold high until step_ack, then fall in the following cycle.
REQ-026 step_req SHALL stay low for at least one cycle between requests.
REQ-027 Strobes arriving while a request is outstanding SHALL be dropped, not queued.
REQ-028 In PAUSE, btn_step with no outstanding request and sort_done=0 SHALL raise step_req next cycle.
REQ-029 btn_step while a request is outstanding SHALL be dropped.
REQ-030 An outstanding request SHALL persist across RUN<->PAUSE transitions until acknowledged.
REQ-031 step_count SHALL increment in the cycle after each step_ack and hold at 2^CNT_W-1.
REQ-032 Simultaneous btn_pause and btn_step in PAUSE: resume wins and the step is dropped.
REQ-033 Simultaneous step_ack and pacing strobe: the ack completes, and the strobe is dropped.
REQ-034 step_ack while step_req=0 SHALL be ignored and SHALL NOT increment step_count.

Reset
REQ-035 On rst the block SHALL enter IDLE and clear step_req, sort_start, step_count and all pace counters to 0, asynchronously.
REQ-036 rst mid-request SHALL drop step_req immediately, and no step SHALL be counted.

Structure
REQ-037 State codes and speed_sel codes SHALL be constants in shared package sort_ctrl_pkg.
REQ-038 Strobe generation SHALL be sub-module pace_gen, with inputs clk_100mhz, rst, tick_1hz, speed_sel and clear, and output strobe.
REQ-039 The implementation SHALL be 120-400 lines of RTL.

Verification
REQ-040 Reset then btn_start -> sort_start is 1 for one cycle, state=01 and step_count=0.
REQ-041 speed_sel=01, 4 ticks, engine acks after 3 cycles -> exactly 2 step_req pulses, each high for 3 cycles; step_count=2.
REQ-042 speed_sel=11, engine acks immediately -> step_req alternates 1,0 and step_count reaches 255 then holds.
REQ-043 Pause with request outstanding, then ack -> state=10 and step_req falls; btn_step -> one more request; btn_pause+btn_step together -> state=01 with no extra request.
REQ-044 sort_done asserted while step_req is pending -> DONE only after the ack; btn_start -> back to RUN with a sort_start pulse.
REQ-045 rst pulse while step_req=1 -> step_req=0 and state=00 before the next clock edge.

Source files
------------

// File: rtl/sort_ctrl_pkg.sv
// Shared constants for the sort step scheduler: FSM state codes and pace
// selection codes.
package sort_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } sched_state_e;

  localparam logic [1:0] SPD_TICK = 2'b00;
  localparam logic [1:0] SPD_HALF = 2'b01;
  localparam logic [1:0] SPD_FAST = 2'b10;
  localparam logic [1:0] SPD_CONT = 2'b11;

  function automatic logic is_active(input sched_state_e st);
    return (st == ST_RUN) || (st == ST_PAUSE);
  endfunction

endpackage

// File: rtl/sort_step_scheduler_pace_gen.sv
// Pacing strobe generator: selects 1 Hz, 0.5 Hz, internal fast or continuous
// strobes; counters restart on clear or on any change of speed_sel.
module pace_gen
  import sort_ctrl_pkg::*;
#(
  parameter int FAST_DIV = 25_000_000
) (
  input  logic       clk_100mhz,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic [1:0] speed_sel,
  input  logic       clear,
  output logic       strobe
);

  localparam int DIV_W = (FAST_DIV > 1) ? $clog2(FAST_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FAST_DIV - 1);

  logic [DIV_W-1:0] fast_cnt_r;
  logic             half_r;
  logic [1:0]       speed_prev_r;
  logic             clr_s;

  assign clr_s = clear | (speed_sel != speed_prev_r);

  // Pace counters: fast divider and tick-parity bit.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      fast_cnt_r   <= '0;
      half_r       <= 1'b0;
      speed_prev_r <= 2'b00;
    end else begin
      speed_prev_r <= speed_sel;
      if (clr_s) begin
        fast_cnt_r <= '0;
        half_r     <= 1'b0;
      end else begin
        if (fast_cnt_r == DIV_LAST) begin
          fast_cnt_r <= '0;
        end else begin
          fast_cnt_r <= fast_cnt_r + DIV_W'(1);
        end
        if (tick_1hz) begin
          half_r <= ~half_r;
        end else begin
          half_r <= half_r;
        end
      end
    end
  end

  // Strobe select; counter-based modes stay quiet while being cleared.
  always_comb begin
    strobe = 1'b0;
    case (speed_sel)
      SPD_TICK: strobe = tick_1hz;
      SPD_HALF: strobe = tick_1hz & half_r & ~clr_s;
      SPD_FAST: strobe = (fast_cnt_r == DIV_LAST) & ~clr_s;
      SPD_CONT: strobe = 1'b1;
      default:  strobe = 1'b0;
    endcase
  end

endmodule

// File: rtl/sort_step_scheduler.sv
// Step scheduler for a visual sort engine: paces compare/swap requests,
// handles start/pause/single-step buttons and counts acknowledged steps.
module sort_step_scheduler
  import sort_ctrl_pkg::*;
#(
  parameter int FAST_DIV = 25_000_000,
  parameter int CNT_W    = 8
) (
  input  logic             clk_100mhz,
  input  logic             rst,
  input  logic             tick_1hz,
  input  logic             btn_start,
  input  logic             btn_pause,
  input  logic             btn_step,
  input  logic [1:0]       speed_sel,
  output logic             step_req,
  input  logic             step_ack,
  input  logic             sort_done,
  output logic             sort_start,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] step_count
);

  localparam logic [CNT_W-1:0] COUNT_MAX = {CNT_W{1'b1}};

  sched_state_e     state_r, state_next_s;
  logic             req_r, req_next_s;
  logic             start_r, start_next_s;
  logic [CNT_W-1:0] count_r, count_next_s;
  logic             launch_s;
  logic             enter_run_s;
  logic             strobe_s;

  pace_gen #(.FAST_DIV(FAST_DIV)) u_pace_gen (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .tick_1hz   (tick_1hz),
    .speed_sel  (speed_sel),
    .clear      (enter_run_s),
    .strobe     (strobe_s)
  );

  // Next-state logic; DONE waits until no request is in flight.
  always_comb begin
    state_next_s = state_r;
    start_next_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (btn_start) begin
          state_next_s = ST_RUN;
          start_next_s = 1'b1;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_RUN: begin
        if (sort_done && !req_r) begin
          state_next_s = ST_DONE;
        end else if (btn_pause) begin
          state_next_s = ST_PAUSE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (sort_done && !req_r) begin
          state_next_s = ST_DONE;
        end else if (btn_pause) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_PAUSE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
    enter_run_s = (state_next_s == ST_RUN) && (state_r != ST_RUN);
  end

  // Request handshake and step counter; new requests only launch from idle handshake.
  always_comb begin
    launch_s = 1'b0;
    if (!req_r && !sort_done && is_active(state_r)) begin
      case (state_r)
        ST_RUN:   launch_s = strobe_s;
        ST_PAUSE: launch_s = btn_step & ~btn_pause;
        default:  launch_s = 1'b0;
      endcase
    end else begin
      launch_s = 1'b0;
    end

    if (req_r) begin
      req_next_s = ~step_ack;
    end else begin
      req_next_s = launch_s;
    end

    if (start_next_s) begin
      count_next_s = '0;
    end else if (req_r && step_ack && (count_r != COUNT_MAX)) begin
      count_next_s = count_r + CNT_W'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      req_r   <= 1'b0;
      start_r <= 1'b0;
      count_r <= '0;
    end else begin
      state_r <= state_next_s;
      req_r   <= req_next_s;
      start_r <= start_next_s;
      count_r <= count_next_s;
    end
  end

  assign state      = state_r;
  assign step_req   = req_r;
  assign sort_start = start_r;
  assign step_count = count_r;

endmodule

// File: tb/tb_sort_step_scheduler.sv
// Self-checking bench for sort_step_scheduler: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_sort_step_scheduler;

  localparam int FAST_DIV = 5;
  localparam int CNT_W    = 8;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk_100mhz = 1'b0;
  logic             rst = 1'b1;
  logic             tick_1hz = 1'b0;
  logic             btn_start = 1'b0;
  logic             btn_pause = 1'b0;
  logic             btn_step = 1'b0;
  logic [1:0]       speed_sel = 2'b00;
  logic             step_ack = 1'b0;
  logic             sort_done = 1'b0;
  logic             step_req;
  logic             sort_start;
  logic [1:0]       state;
  logic [CNT_W-1:0] step_count;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk_100mhz = ~clk_100mhz;

  sort_step_scheduler #(.FAST_DIV(FAST_DIV), .CNT_W(CNT_W)) dut (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .tick_1hz   (tick_1hz),
    .btn_start  (btn_start),
    .btn_pause  (btn_pause),
    .btn_step   (btn_step),
    .speed_sel  (speed_sel),
    .step_req   (step_req),
    .step_ack   (step_ack),
    .sort_done  (sort_done),
    .sort_start (sort_start),
    .state      (state),
    .step_count (step_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: 0=IDLE 1=RUN 2=PAUSE 3=DONE, plain counts since last pace clear.
  int       m_state = 0;
  int       m_cnt = 0;
  int       m_ticks = 0;
  int       m_cyc = 0;
  bit       m_req = 1'b0;
  bit       m_start = 1'b0;
  logic [1:0] m_prev_spd = 2'b00;
  int       nxt;
  bit       clr, strobe, launch;

  always @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      m_state = 0; m_req = 1'b0; m_start = 1'b0; m_cnt = 0;
      m_ticks = 0; m_cyc = 0; m_prev_spd = 2'b00;
    end else begin
      nxt = m_state;
      if ((m_state == 0 || m_state == 3) && btn_start) nxt = 1;
      else if ((m_state == 1 || m_state == 2) && sort_done && !m_req) nxt = 3;
      else if (m_state == 1 && btn_pause) nxt = 2;
      else if (m_state == 2 && btn_pause) nxt = 1;
      clr = (speed_sel != m_prev_spd) || (nxt == 1 && m_state != 1);
      case (speed_sel)
        2'd0:    strobe = tick_1hz;
        2'd1:    strobe = tick_1hz && (m_ticks % 2 == 1) && !clr;
        2'd2:    strobe = (m_cyc % FAST_DIV == FAST_DIV - 1) && !clr;
        default: strobe = 1'b1;
      endcase
      launch = !m_req && !sort_done &&
               ((m_state == 1 && strobe) || (m_state == 2 && btn_step && !btn_pause));
      if (m_req && step_ack && m_cnt < CNT_MAX) m_cnt++;
      m_start = (nxt == 1) && (m_state == 0 || m_state == 3);
      if (m_start) m_cnt = 0;
      m_req = m_req ? !step_ack : launch;
      if (clr) begin
        m_ticks = 0; m_cyc = 0;
      end else begin
        m_ticks += int'(tick_1hz); m_cyc++;
      end
      m_prev_spd = speed_sel;
      m_state = nxt;
    end
  end

  // Compare DUT against the model mid-cycle.
  always @(negedge clk_100mhz) begin
    if (chk_en) begin
      chk("model_state", 32'(state), 32'(m_state));
      chk("model_step_req", 32'(step_req), 32'(m_req));
      chk("model_sort_start", 32'(sort_start), 32'(m_start));
      chk("model_step_count", 32'(step_count), 32'(m_cnt));
    end
  end

  // Engine emulation: ack after ack_lat cycles of step_req (0 = manual).
  int ack_lat = 0;
  int hi_cnt = 0;
  bit spurious_en = 1'b0;

  task automatic next_cyc();
    @(negedge clk_100mhz);
    btn_start = 1'b0; btn_pause = 1'b0; btn_step = 1'b0; tick_1hz = 1'b0;
    if (step_req === 1'b1) begin
      hi_cnt++;
      step_ack = (ack_lat != 0) && (hi_cnt >= ack_lat);
    end else begin
      hi_cnt = 0;
      step_ack = spurious_en && ($urandom_range(0, 5) == 0);
    end
  endtask

  int  pulses, width, alt_bad;
  bit  started, prev_req;

  initial begin
    repeat (3) @(negedge clk_100mhz);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_step_req", 32'(step_req), 32'd0);
    chk("rst_sort_start", 32'(sort_start), 32'd0);
    chk("rst_step_count", 32'(step_count), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Start from IDLE.
    next_cyc(); btn_start = 1'b1;
    next_cyc();
    chk("start_pulse", 32'(sort_start), 32'd1);
    chk("start_state", 32'(state), 32'd1);
    chk("start_count", 32'(step_count), 32'd0);
    next_cyc();
    chk("start_pulse_single", 32'(sort_start), 32'd0);

    // Every 2nd tick, 4 ticks, ack after 3 cycles.
    speed_sel = 2'b01; ack_lat = 3; pulses = 0; width = 0;
    for (int c = 0; c < 45; c++) begin
      next_cyc();
      if (step_req) width++;
      else if (width != 0) begin
        pulses++;
        chk("half_width", 32'(width), 32'd3);
        width = 0;
      end
      if (c % 10 == 5) tick_1hz = 1'b1;
    end
    chk("half_pulses", 32'(pulses), 32'd2);
    chk("half_count", 32'(step_count), 32'd2);

    // Back-to-back with immediate ack: alternation and saturation.
    speed_sel = 2'b11; ack_lat = 1; alt_bad = 0; started = 1'b0; prev_req = 1'b0;
    for (int c = 0; c < 560; c++) begin
      next_cyc();
      if (started && step_req == prev_req) alt_bad++;
      if (step_req) started = 1'b1;
      prev_req = step_req;
    end
    chk("cont_alternate", 32'(alt_bad), 32'd0);
    chk("cont_saturate", 32'(step_count), 32'd255);

    speed_sel = 2'b00;
    repeat (4) next_cyc();
    ack_lat = 0;

    // Pause with a request outstanding, single step, then pause+step together.
    tick_1hz = 1'b1;
    next_cyc();
    chk("pause_req_up", 32'(step_req), 32'd1);
    btn_pause = 1'b1;
    next_cyc();
    chk("pause_state", 32'(state), 32'd2);
    chk("pause_req_held", 32'(step_req), 32'd1);
    step_ack = 1'b1;
    next_cyc();
    chk("pause_req_fall", 32'(step_req), 32'd0);
    chk("pause_state_kept", 32'(state), 32'd2);
    btn_step = 1'b1;
    next_cyc();
    chk("pause_step_req", 32'(step_req), 32'd1);
    step_ack = 1'b1;
    next_cyc();
    chk("pause_step_done", 32'(step_req), 32'd0);
    btn_pause = 1'b1; btn_step = 1'b1;
    next_cyc();
    chk("resume_state", 32'(state), 32'd1);
    chk("resume_no_req", 32'(step_req), 32'd0);
    next_cyc();
    chk("resume_no_req_later", 32'(step_req), 32'd0);

    // sort_done while a request is pending.
    tick_1hz = 1'b1;
    next_cyc();
    sort_done = 1'b1;
    repeat (3) next_cyc();
    chk("done_wait_state", 32'(state), 32'd1);
    chk("done_wait_req", 32'(step_req), 32'd1);
    step_ack = 1'b1;
    next_cyc();
    chk("done_ack_state", 32'(state), 32'd1);
    next_cyc();
    chk("done_state", 32'(state), 32'd3);
    sort_done = 1'b0; btn_start = 1'b1;
    next_cyc();
    chk("restart_pulse", 32'(sort_start), 32'd1);
    chk("restart_state", 32'(state), 32'd1);
    chk("restart_count", 32'(step_count), 32'd0);

    // Asynchronous reset mid-request.
    tick_1hz = 1'b1;
    next_cyc();
    chk("rst_mid_req_up", 32'(step_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_req", 32'(step_req), 32'd0);
    chk("rst_mid_state", 32'(state), 32'd0);
    chk("rst_mid_count", 32'(step_count), 32'd0);
    next_cyc();
    rst = 1'b0;

    // Randomized traffic against the model.
    spurious_en = 1'b1; ack_lat = 2;
    for (int c = 0; c < 3000; c++) begin
      next_cyc();
      rst = 1'b0;
      if (!step_req) ack_lat = $urandom_range(1, 4);
      tick_1hz  = ($urandom_range(0, 6) == 0);
      btn_start = ($urandom_range(0, 40) == 0);
      btn_pause = ($urandom_range(0, 30) == 0);
      btn_step  = ($urandom_range(0, 8) == 0);
      if ($urandom_range(0, 150) == 0) speed_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 100) == 0) sort_done = ~sort_done;
      if ($urandom_range(0, 999) == 0) begin
        #2 rst = 1'b1;
      end
    end
    next_cyc();
    rst = 1'b0;
    next_cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
